// File: rtl/control_unit_if.sv
// Bundle between the control unit and the rest of the core: ROM fetch port,
// data-RAM strobes, datapath control word and status flags.
interface control_unit_if #(
  parameter int PC_WIDTH = 8
);
  logic                run_en;
  logic [15:0]         instr_data;
  logic                alu_zero;
  logic                alu_carry;
  logic [PC_WIDTH-1:0] rom_addr;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] ram_addr;
  logic                ram_re;
  logic                ram_we;
  logic [2:0]          alu_opcode;
  logic [7:0]          imm_data;
  logic [3:0]          write_addr;
  logic [3:0]          ra_addr;
  logic [3:0]          rb_addr;
  logic                write_en;
  logic                write_alu;
  logic                is_load;
  logic                imm_flag;
  logic                cpu_paused;
  logic                zero_flag;
  logic                carry_flag;
  logic                halted;

  modport master (
    input  run_en, instr_data, alu_zero, alu_carry,
    output rom_addr, pc, ram_addr, ram_re, ram_we, alu_opcode, imm_data,
           write_addr, ra_addr, rb_addr, write_en, write_alu, is_load,
           imm_flag, cpu_paused, zero_flag, carry_flag, halted
  );

  modport slave (
    output run_en, instr_data, alu_zero, alu_carry,
    input  rom_addr, pc, ram_addr, ram_re, ram_we, alu_opcode, imm_data,
           write_addr, ra_addr, rb_addr, write_en, write_alu, is_load,
           imm_flag, cpu_paused, zero_flag, carry_flag, halted
  );
endinterface

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit core: owns PC, IR and the Z/C
// flags, and decodes the control word for the datapath from state and IR.
module control_unit #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  control_unit_if.master bus
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    HALT
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JC  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              state;
  logic [PC_WIDTH-1:0] pc_q;
  logic [15:0]         ir;
  logic                zero_q;
  logic                carry_q;

  logic [3:0]          op;
  logic [3:0]          rd;
  logic [3:0]          rs1;
  logic [3:0]          rs2;
  logic [PC_WIDTH-1:0] a8;
  logic                is_alu;

  assign op     = ir[15:12];
  assign rd     = ir[11:8];
  assign rs1    = ir[7:4];
  assign rs2    = ir[3:0];
  assign a8     = PC_WIDTH'(ir[7:0]);
  assign is_alu = ~op[3];

  // Branches test the latched flags, never the live datapath outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      pc_q    <= RESET_PC;
      ir      <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.run_en) state <= DECODE;
        end
        DECODE: begin
          ir    <= bus.instr_data;
          pc_q  <= pc_q + PC_WIDTH'(1);
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          if (is_alu) begin
            zero_q  <= bus.alu_zero;
            carry_q <= bus.alu_carry;
          end
          case (op)
            OP_LD:   state <= MEM;
            OP_HLT:  state <= HALT;
            OP_JMP:  pc_q  <= a8;
            OP_JZ:   if (zero_q)  pc_q <= a8;
            OP_JC:   if (carry_q) pc_q <= a8;
            default: ;
          endcase
        end
        MEM: begin
          state <= FETCH;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // Control word is a pure function of state and IR, so reset clears it at once.
  always_comb begin
    bus.ram_addr   = '0;
    bus.ram_re     = 1'b0;
    bus.ram_we     = 1'b0;
    bus.alu_opcode = 3'd0;
    bus.write_addr = 4'd0;
    bus.ra_addr    = 4'd0;
    bus.rb_addr    = 4'd0;
    bus.write_en   = 1'b0;
    bus.write_alu  = 1'b0;
    bus.is_load    = 1'b0;
    bus.imm_flag   = 1'b0;
    case (state)
      EXEC: begin
        if (is_alu) begin
          bus.write_en   = 1'b1;
          bus.write_alu  = 1'b1;
          bus.ra_addr    = rs1;
          bus.rb_addr    = rs2;
          bus.write_addr = rd;
          bus.alu_opcode = op[2:0];
        end else begin
          case (op)
            OP_LDI: begin
              bus.write_en   = 1'b1;
              bus.imm_flag   = 1'b1;
              bus.write_addr = rd;
            end
            OP_LD: begin
              bus.ram_re   = 1'b1;
              bus.ram_addr = a8;
            end
            OP_ST: begin
              bus.ram_we   = 1'b1;
              bus.ram_addr = a8;
              bus.ra_addr  = rd;
            end
            default: ;
          endcase
        end
      end
      MEM: begin
        bus.write_en   = 1'b1;
        bus.is_load    = 1'b1;
        bus.write_addr = rd;
        bus.ram_addr   = a8;
      end
      default: ;
    endcase
  end

  assign bus.rom_addr   = pc_q;
  assign bus.pc         = pc_q;
  assign bus.imm_data   = ir[7:0];
  assign bus.zero_flag  = zero_q;
  assign bus.carry_flag = carry_q;
  assign bus.halted     = (state == HALT);
  assign bus.cpu_paused = (state == HALT) || ((state == FETCH) && !bus.run_en);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, hand-written
// branch/pause/halt/reset sequences, and a random program against an ISA model.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  control_unit_if #(.PC_WIDTH(8)) bus ();

  control_unit #(
    .PC_WIDTH(8),
    .RESET_PC(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [15:0] rom [256];

  always @(posedge clk) bus.instr_data <= rom[bus.rom_addr];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] rom_addr;
    logic [7:0] ram_addr;
    logic       ram_re;
    logic       ram_we;
    logic [2:0] alu_opcode;
    logic [3:0] write_addr;
    logic [3:0] ra_addr;
    logic [3:0] rb_addr;
    logic       write_en;
    logic       write_alu;
    logic       is_load;
    logic       imm_flag;
    logic       cpu_paused;
    logic       zero_flag;
    logic       carry_flag;
    logic       halted;
  } snap_t;

  typedef struct {
    logic [15:0] instr;
    logic        z_in;
    logic        c_in;
    logic        we;
    logic        walu;
    logic        immf;
    logic        ram_re;
    logic        ram_we;
    logic [2:0]  aop;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  wa;
    logic [7:0]  ram_addr;
    logic [7:0]  imm;
    logic [3:0]  mem_wa;
    logic        z_after;
    logic        c_after;
    int          cycles;
  } vec_t;

  vec_t vecs [9];

  function automatic snap_t dut_snap();
    snap_t s;
    s.pc         = bus.pc;
    s.rom_addr   = bus.rom_addr;
    s.ram_addr   = bus.ram_addr;
    s.ram_re     = bus.ram_re;
    s.ram_we     = bus.ram_we;
    s.alu_opcode = bus.alu_opcode;
    s.write_addr = bus.write_addr;
    s.ra_addr    = bus.ra_addr;
    s.rb_addr    = bus.rb_addr;
    s.write_en   = bus.write_en;
    s.write_alu  = bus.write_alu;
    s.is_load    = bus.is_load;
    s.imm_flag   = bus.imm_flag;
    s.cpu_paused = bus.cpu_paused;
    s.zero_flag  = bus.zero_flag;
    s.carry_flag = bus.carry_flag;
    s.halted     = bus.halted;
    return s;
  endfunction

  function automatic snap_t idle(logic [7:0] p, logic z, logic c, logic paused);
    snap_t s;
    s            = '0;
    s.pc         = p;
    s.rom_addr   = p;
    s.zero_flag  = z;
    s.carry_flag = c;
    s.cpu_paused = paused;
    return s;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkSnap(string name, snap_t exp);
    checkOutput(name, 64'(dut_snap()), 64'(exp));
  endtask

  task automatic applyStimulus(logic z, logic c);
    bus.alu_zero  = z;
    bus.alu_carry = c;
    #1;
  endtask

  task automatic doReset();
    rst           = 1'b1;
    bus.run_en    = 1'b1;
    bus.alu_zero  = 1'b0;
    bus.alu_carry = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fillNop();
    for (int i = 0; i < 256; i++) rom[i] = 16'hE000;
  endtask

  task automatic runInstr(string name, logic z, logic c, logic [7:0] exp_pc);
    repeat (3) begin
      applyStimulus(z, c);
      @(negedge clk);
    end
    #1;
    checkOutput(name, 64'(bus.pc), 64'(exp_pc));
  endtask

  // Instruction-level reference: one ISA step per iteration, pauses inserted at random.
  task automatic randomTest();
    logic [7:0]  pc_m;
    logic        z_m;
    logic        c_m;
    logic [15:0] ir;
    logic [3:0]  op;
    logic        dz;
    logic        dc;
    snap_t       e;
    for (int i = 0; i < 256; i++) begin
      ir = 16'($urandom);
      if (ir[15:12] == 4'hF) ir[15:12] = 4'hE;
      rom[i] = ir;
    end
    doReset();
    pc_m = 8'h00;
    z_m  = 1'b0;
    c_m  = 1'b0;
    for (int n = 0; n < 250; n++) begin
      ir = rom[pc_m];
      op = ir[15:12];
      if ($urandom_range(0, 7) == 0) begin
        bus.run_en = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          applyStimulus(1'($urandom), 1'($urandom));
          checkSnap("rnd_pause", idle(pc_m, z_m, c_m, 1'b1));
          @(negedge clk);
        end
        bus.run_en = 1'b1;
      end
      applyStimulus(1'($urandom), 1'($urandom));
      checkSnap("rnd_fetch", idle(pc_m, z_m, c_m, 1'b0));
      @(negedge clk);
      applyStimulus(1'($urandom), 1'($urandom));
      checkSnap("rnd_decode", idle(pc_m, z_m, c_m, 1'b0));
      @(negedge clk);
      pc_m = pc_m + 8'd1;
      dz   = 1'($urandom);
      dc   = 1'($urandom);
      applyStimulus(dz, dc);
      e = idle(pc_m, z_m, c_m, 1'b0);
      if (op < 4'h8) begin
        e.write_en   = 1'b1;
        e.write_alu  = 1'b1;
        e.alu_opcode = op[2:0];
        e.ra_addr    = ir[7:4];
        e.rb_addr    = ir[3:0];
        e.write_addr = ir[11:8];
      end else if (op == 4'h8) begin
        e.write_en   = 1'b1;
        e.imm_flag   = 1'b1;
        e.write_addr = ir[11:8];
      end else if (op == 4'h9) begin
        e.ram_re   = 1'b1;
        e.ram_addr = ir[7:0];
      end else if (op == 4'hA) begin
        e.ram_we   = 1'b1;
        e.ram_addr = ir[7:0];
        e.ra_addr  = ir[11:8];
      end
      checkSnap("rnd_exec", e);
      if (op == 4'h8) checkOutput("rnd_imm", 64'(bus.imm_data), 64'(ir[7:0]));
      @(negedge clk);
      if (op < 4'h8) begin
        z_m = dz;
        c_m = dc;
      end
      if ((op == 4'hB) || (op == 4'hC && z_m) || (op == 4'hD && c_m)) pc_m = ir[7:0];
      if (op == 4'h9) begin
        applyStimulus(1'($urandom), 1'($urandom));
        e            = idle(pc_m, z_m, c_m, 1'b0);
        e.write_en   = 1'b1;
        e.is_load    = 1'b1;
        e.write_addr = ir[11:8];
        e.ram_addr   = ir[7:0];
        checkSnap("rnd_mem", e);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    snap_t      e;
    vec_t       v;
    logic       zp;
    logic       cp;
    logic [7:0] pcv;

    //           instr     z  c  we walu immf re we  aop   ra     rb     wa     raddr  imm    mwa    z  c  cyc
    vecs[0] = '{16'h8105, 0, 0, 1, 0,   1,   0, 0, 3'd0, 4'h0, 4'h0, 4'h1, 8'h00, 8'h05, 4'h0, 0, 0, 3};
    vecs[1] = '{16'h0312, 1, 0, 1, 1,   0,   0, 0, 3'd0, 4'h1, 4'h2, 4'h3, 8'h00, 8'h00, 4'h0, 1, 0, 3};
    vecs[2] = '{16'h8207, 0, 1, 1, 0,   1,   0, 0, 3'd0, 4'h0, 4'h0, 4'h2, 8'h00, 8'h07, 4'h0, 1, 0, 3};
    vecs[3] = '{16'h5A3C, 0, 1, 1, 1,   0,   0, 0, 3'd5, 4'h3, 4'hC, 4'hA, 8'h00, 8'h00, 4'h0, 0, 1, 3};
    vecs[4] = '{16'h9420, 1, 1, 0, 0,   0,   1, 0, 3'd0, 4'h0, 4'h0, 4'h0, 8'h20, 8'h00, 4'h4, 0, 1, 4};
    vecs[5] = '{16'hA230, 1, 1, 0, 0,   0,   0, 1, 3'd0, 4'h2, 4'h0, 4'h0, 8'h30, 8'h00, 4'h0, 0, 1, 3};
    vecs[6] = '{16'hE000, 1, 1, 0, 0,   0,   0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 4'h0, 0, 1, 3};
    vecs[7] = '{16'h7FFF, 1, 1, 1, 1,   0,   0, 0, 3'd7, 4'hF, 4'hF, 4'hF, 8'h00, 8'h00, 4'h0, 1, 1, 3};
    vecs[8] = '{16'h3000, 0, 0, 1, 1,   0,   0, 0, 3'd3, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 4'h0, 0, 0, 3};

    // Directed vector table, executed back to back from address 0.
    fillNop();
    for (int i = 0; i < 9; i++) rom[i] = vecs[i].instr;
    doReset();
    zp = 1'b0;
    cp = 1'b0;
    for (int i = 0; i < 9; i++) begin
      v   = vecs[i];
      pcv = 8'(i);
      applyStimulus(v.z_in, v.c_in);
      checkSnap($sformatf("vec%0d_fetch", i), idle(pcv, zp, cp, 1'b0));
      @(negedge clk);
      applyStimulus(v.z_in, v.c_in);
      checkSnap($sformatf("vec%0d_decode", i), idle(pcv, zp, cp, 1'b0));
      @(negedge clk);
      applyStimulus(v.z_in, v.c_in);
      e            = idle(pcv + 8'd1, zp, cp, 1'b0);
      e.write_en   = v.we;
      e.write_alu  = v.walu;
      e.imm_flag   = v.immf;
      e.ram_re     = v.ram_re;
      e.ram_we     = v.ram_we;
      e.alu_opcode = v.aop;
      e.ra_addr    = v.ra;
      e.rb_addr    = v.rb;
      e.write_addr = v.wa;
      e.ram_addr   = v.ram_addr;
      checkSnap($sformatf("vec%0d_exec", i), e);
      if (v.immf) checkOutput($sformatf("vec%0d_imm", i), 64'(bus.imm_data), 64'(v.imm));
      @(negedge clk);
      if (v.cycles == 4) begin
        applyStimulus(v.z_in, v.c_in);
        e            = idle(pcv + 8'd1, v.z_after, v.c_after, 1'b0);
        e.write_en   = 1'b1;
        e.is_load    = 1'b1;
        e.write_addr = v.mem_wa;
        e.ram_addr   = v.ram_addr;
        checkSnap($sformatf("vec%0d_mem", i), e);
        @(negedge clk);
      end
      zp = v.z_after;
      cp = v.c_after;
    end
    applyStimulus(1'b0, 1'b0);
    checkSnap("vec_end_fetch", idle(8'd9, zp, cp, 1'b0));

    // Branches: latched flags only, JMP from 0xFF, NOP wrapping 0xFF -> 0x00.
    fillNop();
    rom[8'h00] = 16'h0000;
    rom[8'h01] = 16'hC040;
    rom[8'h40] = 16'hD050;
    rom[8'h41] = 16'h0000;
    rom[8'h42] = 16'hC080;
    rom[8'h43] = 16'hD0FF;
    rom[8'hFF] = 16'hB010;
    rom[8'h11] = 16'hB0FF;
    doReset();
    runInstr("br_alu_z1",        1'b1, 1'b0, 8'h01);
    runInstr("br_jz_taken",      1'b0, 1'b0, 8'h40);
    runInstr("br_jc_live_c_only", 1'b0, 1'b1, 8'h41);
    runInstr("br_alu_c1",        1'b0, 1'b1, 8'h42);
    runInstr("br_jz_live_z_only", 1'b1, 1'b0, 8'h43);
    runInstr("br_jc_taken",      1'b0, 1'b0, 8'hFF);
    runInstr("br_jmp_from_ff",   1'b0, 1'b0, 8'h10);
    rom[8'hFF] = 16'hE000;
    runInstr("br_nop",           1'b0, 1'b0, 8'h11);
    runInstr("br_jmp_to_ff",     1'b0, 1'b0, 8'hFF);
    runInstr("br_nop_wrap",      1'b0, 1'b0, 8'h00);
    @(negedge clk);

    // Pause at FETCH, resume, then drop run_en mid-instruction.
    fillNop();
    doReset();
    bus.run_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0);
      checkSnap($sformatf("pause_%0d", k), idle(8'h00, 1'b0, 1'b0, 1'b1));
      @(negedge clk);
    end
    bus.run_en = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkSnap("resume_fetch", idle(8'h00, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    bus.run_en = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkSnap("runen_low_decode", idle(8'h00, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    checkSnap("runen_low_exec", idle(8'h01, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0);
      checkSnap($sformatf("repause_%0d", k), idle(8'h01, 1'b0, 1'b0, 1'b1));
      @(negedge clk);
    end

    // HLT is terminal.
    fillNop();
    rom[0] = 16'hF000;
    doReset();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0);
      @(negedge clk);
    end
    applyStimulus(1'b1, 1'b1);
    checkSnap("hlt_exec", idle(8'h01, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    e        = idle(8'h01, 1'b0, 1'b0, 1'b1);
    e.halted = 1'b1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b1);
      checkSnap($sformatf("halted_%0d", k), e);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of an ALU EXEC cycle.
    fillNop();
    rom[0] = 16'h0312;
    rom[1] = 16'h0445;
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0);
    checkSnap("pre_rst_fetch", idle(8'h01, 1'b1, 1'b1, 1'b0));
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    e            = idle(8'h02, 1'b1, 1'b1, 1'b0);
    e.write_en   = 1'b1;
    e.write_alu  = 1'b1;
    e.ra_addr    = 4'h4;
    e.rb_addr    = 4'h5;
    e.write_addr = 4'h4;
    checkSnap("pre_rst_exec", e);
    #1 rst = 1'b1;
    #1;
    checkSnap("rst_mid_exec", idle(8'h00, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkSnap("post_rst_fetch", idle(8'h00, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    e            = idle(8'h01, 1'b0, 1'b0, 1'b0);
    e.write_en   = 1'b1;
    e.write_alu  = 1'b1;
    e.ra_addr    = 4'h1;
    e.rb_addr    = 4'h2;
    e.write_addr = 4'h3;
    checkSnap("post_rst_exec", e);
    @(negedge clk);

    randomTest();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle fetch/decode/execute sequencer for the 8-bit core. It drives every control input of the datapath (register addresses, write enable, ALU opcode, immediate, load/imm/ALU select, pause) and consumes its alu_zero/alu_carry outputs. It also owns the PC, the synchronous instruction ROM address, and the data-RAM read/write strobes.

Parameters:
PC_WIDTH, 8, width of the PC and of the ROM and RAM addresses
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
run_en  input  1  when 0, the FSM holds in FETCH (single-step/pause)
instr_data  input  16  ROM read data, valid 1 cycle after rom_addr
alu_zero  input  1  from datapath
alu_carry  input  1  from datapath
rom_addr  output  PC_WIDTH  equals pc
pc  output  PC_WIDTH  program counter
ram_addr  output  PC_WIDTH  data RAM address, IR[7:0]
ram_re  output  1  RAM read strobe (synchronous RAM, 1-cycle latency)
ram_we  output  1  RAM write strobe (write data is datapath read_a)
alu_opcode  output  3  to datapath
imm_data  output  8  IR[7:0]
write_addr  output  4  IR[11:8]
ra_addr  output  4  register A select
rb_addr  output  4  register B select
write_en  output  1  register-file write
write_alu  output  1  select ALU result for write-back
is_load  output  1  select ram_data for write-back
imm_flag  output  1  select imm_data for write-back
cpu_paused  output  1  core idle (halted or run_en held low in FETCH)
zero_flag  output  1  latched Z
carry_flag  output  1  latched C
halted  output  1  HLT executed

Behaviour:
- Instruction format: op=IR[15:12], rd=IR[11:8], rs1=IR[7:4], rs2=IR[3:0], a8/imm8=IR[7:0].
- Opcodes:
  - 0x0–0x7: ALU, rd = rs1 op rs2, alu_opcode=op[2:0]
  - 0x8: LDI rd, imm8
  - 0x9: LD rd, [a8]
  - 0xA: ST rd, [a8] (source register is rd)
  - 0xB: JMP a8
  - 0xC: JZ a8
  - 0xD: JC a8
  - 0xE: NOP
  - 0xF: HLT
- States and transitions:
  - FETCH: rom_addr=pc. If run_en, go to DECODE.
  - DECODE: ir<=instr_data; pc<=pc+1 (wraps 0xFF->0x00); go to EXEC.
  - EXEC: go to MEM for LD, HALT for HLT, otherwise FETCH.
  - MEM: go to FETCH.
  - HALT: terminal; only rst exits.
- Outputs are combinational functions of state and ir. All strobes, selects and addresses are 0 unless listed below.
- ALU in EXEC:
  - write_en=1, write_alu=1, ra_addr=rs1, rb_addr=rs2, write_addr=rd, alu_opcode=op[2:0].
  - On the EXEC edge: zero_flag<=alu_zero, carry_flag<=alu_carry.
  - Flags change on ALU ops only.
- LDI in EXEC: write_en=1, imm_flag=1, write_addr=rd, imm_data=imm8.
- LD:
  - EXEC: ram_re=1, ram_addr=a8.
  - MEM: write_en=1, is_load=1, write_addr=rd, ram_addr held.
- ST in EXEC: ram_we=1 for exactly one cycle, ram_addr=a8, ra_addr=rd.
- Branches in EXEC:
  - pc<=a8 for JMP.
  - pc<=a8 for JZ when zero_flag=1.
  - pc<=a8 for JC when carry_flag=1.
  - Otherwise pc keeps its incremented value. The flag test uses the latched flag, not the live input.
- Cycles per instruction: 3 for all instructions except LD, which takes 4.
- write_en is asserted for at most 1 cycle per instruction; write_alu, is_load and imm_flag are mutually exclusive.
- cpu_paused=1 when state is HALT, or when state is FETCH and run_en=0. halted=1 in HALT.
- Deasserting run_en mid-instruction has no effect until the next FETCH.
- Reset (asynchronous): state=FETCH, pc=RESET_PC, ir=0, flags=0, halted=0.
  - All strobes go to 0 immediately, including mid-EXEC and mid-MEM.
  - No partial write or RAM access completes after rst rises.
  - The first fetch occurs from RESET_PC after rst falls.

Test Plan:
1. Reset, ROM[0]=0x8105 (LDI r1,05), run_en=1 -> in cycle 3: write_en=1, imm_flag=1, write_addr=1, imm_data=05; pc=1; write_en 0 in all other cycles.
2. ROM=0x0312 (ADD r3,r1,r2), drive alu_zero=1, alu_carry=0 during EXEC -> write_alu=1, alu_opcode=0, ra=1, rb=2, write_addr=3; after the edge zero_flag=1, carry_flag=0. Following LDI -> flags unchanged.
3. JZ 0x40 with zero_flag=1 -> pc=0x40 on the next FETCH. Same with zero_flag=0 -> pc=previous+1. JMP at pc=0xFF with target 0x10 -> pc=0x10. NOP at 0xFF -> pc wraps to 0x00.
4. LD r4,[0x20] -> EXEC: ram_re=1, ram_addr=0x20. MEM: write_en=1, is_load=1, write_addr=4. Total 4 cycles. ST r2,[0x30] -> single ram_we pulse, ra_addr=2, ram_addr=0x30, write_en=0.
5. run_en=0 at FETCH -> cpu_paused=1, pc frozen for 5 cycles. run_en=1 -> resumes.
6. HLT -> halted=1 and cpu_paused=1 indefinitely, no strobes. Assert rst mid-EXEC of an ALU op -> write_en drops the same instant, pc=0x00, flags=0, fetch restarts at 0.
